// File: rtl/branch_redirect_ctrl_pkg.sv
// branch_redirect_ctrl_pkg: jump encodings, CCR flag indices and FSM state type
package branch_redirect_ctrl_pkg;
  localparam logic [1:0] JZ  = 2'b00;
  localparam logic [1:0] JN  = 2'b01;
  localparam logic [1:0] JC  = 2'b10;
  localparam logic [1:0] JMP = 2'b11;
  localparam int CCR_Z = 0;
  localparam int CCR_N = 1;
  localparam int CCR_C = 2;
  typedef enum logic [1:0] {IDLE, REDIRECT, SQUASH} state_e;
  // Conditional jumps consume the flag whose index equals their encoding.
  function automatic logic [3:0] clear_mask(input logic [1:0] jt);
    return (jt == JMP) ? 4'b0000 : 4'b0001 << jt;
  endfunction
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational taken decision for the EX-stage jump
module branch_cond_eval
  import branch_redirect_ctrl_pkg::*;
(
  input  logic [3:0] ccr_i,
  input  logic [1:0] jmp_type_i,
  input  logic       br_valid_i,
  output logic       taken_o
);
  // JZ/JN/JC encodings coincide with the Z/N/C flag indices.
  assign taken_o = br_valid_i & ((jmp_type_i == JMP) | ccr_i[jmp_type_i]);
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: redirect/flush sequencing, target latch and branch counters
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  input  logic [1:0]       jmp_type,
  input  logic [3:0]       ccr,
  input  logic [PC_W-1:0]  br_target,
  input  logic             stall_in,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [3:0]       ccr_clear,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);
  state_e           state_q;
  logic             taken, accept;
  logic             redirect_valid_q, flush_ifid_q, flush_idex_q;
  logic [3:0]       ccr_clear_q;
  logic [PC_W-1:0]  redirect_pc_q;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, taken_cnt_q, taken_cnt_d;

  branch_cond_eval u_cond (
    .ccr_i      (ccr),
    .jmp_type_i (jmp_type),
    .br_valid_i (br_valid),
    .taken_o    (taken)
  );

  assign accept = (state_q == IDLE) & br_valid & ~stall_in;

  always_comb begin
    br_cnt_d    = (accept && !(&br_cnt_q)) ? br_cnt_q + 1'b1 : br_cnt_q;
    taken_cnt_d = (accept && taken && !(&taken_cnt_q)) ? taken_cnt_q + 1'b1 : taken_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      redirect_valid_q <= 1'b0;
      flush_ifid_q     <= 1'b0;
      flush_idex_q     <= 1'b0;
      ccr_clear_q      <= '0;
      redirect_pc_q    <= '0;
      br_cnt_q         <= '0;
      taken_cnt_q      <= '0;
    end else begin
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
      case (state_q)
        IDLE: if (accept && taken) begin
          state_q          <= REDIRECT;
          redirect_valid_q <= 1'b1;
          flush_ifid_q     <= 1'b1;
          flush_idex_q     <= 1'b1;
          redirect_pc_q    <= br_target;
          ccr_clear_q      <= clear_mask(jmp_type);
        end
        REDIRECT: begin
          ccr_clear_q <= '0;
          if (!stall_in) begin
            state_q          <= SQUASH;
            redirect_valid_q <= 1'b0;
            flush_idex_q     <= 1'b0;
          end
        end
        SQUASH: if (!stall_in) begin
          state_q      <= IDLE;
          flush_ifid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush_ifid     = flush_ifid_q;
  assign flush_idex     = flush_idex_q;
  assign ccr_clear      = ccr_clear_q;
  assign br_cnt         = br_cnt_q;
  assign taken_cnt      = taken_cnt_q;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed vectors checked against a per-cycle behavioural model
module tb_branch_redirect_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_valid = 1'b0;
  logic [1:0]  jmp_type = 2'b00;
  logic [3:0]  ccr = 4'h0;
  logic [31:0] br_target = '0;
  logic        stall_in = 1'b0;

  logic        rv, fi, fd, rv4, fi4, fd4;
  logic [31:0] pc, pc4;
  logic [3:0]  clr, clr4;
  logic [15:0] bc, tc;
  logic [3:0]  bc4, tc4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .jmp_type(jmp_type), .ccr(ccr),
    .br_target(br_target), .stall_in(stall_in), .redirect_valid(rv), .redirect_pc(pc),
    .flush_ifid(fi), .flush_idex(fd), .ccr_clear(clr), .br_cnt(bc), .taken_cnt(tc)
  );

  branch_redirect_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .jmp_type(jmp_type), .ccr(ccr),
    .br_target(br_target), .stall_in(stall_in), .redirect_valid(rv4), .redirect_pc(pc4),
    .flush_ifid(fi4), .flush_idex(fd4), .ccr_clear(clr4), .br_cnt(bc4), .taken_cnt(tc4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_taken(input logic [1:0] jt, input logic [3:0] f);
    return (jt == 2'b00 && f[0]) || (jt == 2'b01 && f[1]) || (jt == 2'b10 && f[2]) || jt == 2'b11;
  endfunction

  function automatic logic [3:0] flag_of(input logic [1:0] jt);
    return jt == 2'b00 ? 4'b0001 : jt == 2'b01 ? 4'b0010 : jt == 2'b10 ? 4'b0100 : 4'b0000;
  endfunction

  // Model: where we are in the redirect sequence, plus unbounded branch counts.
  int          m_redirect_left;
  bit          m_in_squash, m_first;
  logic [31:0] m_pc;
  logic [3:0]  m_flag;
  int          m_br, m_tk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_redirect_left <= 0; m_in_squash <= 0; m_first <= 0;
      m_pc <= '0; m_flag <= '0; m_br <= 0; m_tk <= 0;
    end else begin
      m_first <= 0;
      if (!stall_in) begin
        if (m_redirect_left > 0) begin
          m_redirect_left <= 0; m_in_squash <= 1;
        end else if (m_in_squash) begin
          m_in_squash <= 0;
        end else if (br_valid) begin
          m_br <= m_br + 1;
          if (is_taken(jmp_type, ccr)) begin
            m_tk <= m_tk + 1; m_redirect_left <= 1; m_first <= 1;
            m_pc <= br_target; m_flag <= flag_of(jmp_type);
          end
        end
      end
    end
  end

  function automatic int sat(input int v, input int lim);
    return v > lim ? lim : v;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("redirect_valid", rv, m_redirect_left > 0);
      chk("flush_ifid", fi, m_redirect_left > 0 || m_in_squash);
      chk("flush_idex", fd, m_redirect_left > 0);
      chk("ccr_clear", clr, m_first ? m_flag : 4'b0000);
      chk("redirect_pc", pc, m_pc);
      chk("br_cnt", bc, sat(m_br, 65535));
      chk("taken_cnt", tc, sat(m_tk, 65535));
      chk("w4_outputs", {rv4, fi4, fd4, clr4, pc4}, {rv, fi, fd, clr, pc});
      chk("w4_br_cnt", bc4, sat(m_br, 15));
      chk("w4_taken_cnt", tc4, sat(m_tk, 15));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) cyc();
    // first edge after reset release accepts a taken JZ
    br_valid = 1; jmp_type = 2'b00; ccr = 4'b0001; br_target = 32'h40;
    rst_n = 1;
    cyc(); br_valid = 0;
    chk("jz_rv", rv, 1); chk("jz_pc", pc, 32'h40); chk("jz_flushes", {fi, fd}, 2'b11);
    chk("jz_clear", clr, 4'b0001); chk("jz_cnts", {bc, tc}, {16'd1, 16'd1});
    cyc();
    chk("jz_squash", {rv, fi, fd, clr}, {1'b0, 1'b1, 1'b0, 4'b0000});
    cyc();
    chk("jz_idle", {rv, fi, fd}, 3'b000);
    // not-taken JN
    br_valid = 1; jmp_type = 2'b01; ccr = 4'b0000; br_target = 32'h80;
    cyc(); br_valid = 0;
    chk("jn_none", {rv, fi, fd, clr}, 7'b0);
    chk("jn_cnts", {bc, tc}, {16'd2, 16'd1}); chk("jn_pc_hold", pc, 32'h40);
    // branch offered under stall is not accepted
    br_valid = 1; jmp_type = 2'b00; ccr = 4'b0001; stall_in = 1;
    cyc(); br_valid = 0; stall_in = 0;
    chk("stall_no_accept", {rv, bc}, {1'b0, 16'd2});
    // JMP with 3 stall cycles after acceptance
    br_valid = 1; jmp_type = 2'b11; ccr = 4'hF; br_target = 32'h1234;
    cyc(); br_valid = 0; stall_in = 1;
    chk("jmp_clear", clr, 4'b0000); chk("jmp_rv", rv, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("jmp_held", {rv, fi, fd, clr, pc}, {3'b111, 4'b0000, 32'h1234});
    end
    stall_in = 0;
    cyc();
    chk("jmp_squash", {rv, fi, fd}, 3'b010);
    cyc();
    chk("jmp_idle", fi, 0);
    // JC taken, br_valid kept high through REDIRECT and SQUASH
    br_valid = 1; jmp_type = 2'b10; ccr = 4'b0100; br_target = 32'h200;
    cyc(); chk("jc_clear", clr, 4'b0100);
    cyc(); cyc(); br_valid = 0;
    chk("jc_ignored", {bc, tc}, {16'd4, 16'd3});
    cyc();
    // asynchronous reset mid-REDIRECT
    br_valid = 1; jmp_type = 2'b11; br_target = 32'h300;
    cyc(); br_valid = 0;
    chk("pre_rst_rv", rv, 1);
    #1 rst_n = 0;
    #1 chk("async_rst", {rv, fi, fd, clr, pc, bc, tc}, '0);
    cyc(); rst_n = 1;
    cyc(); chk("no_squash_after_rst", {rv, fi, fd, clr}, 7'b0);
    cyc();
    // 17 taken JMPs saturate the narrow counters
    for (int i = 0; i < 17; i++) begin
      br_valid = 1; jmp_type = 2'b11; br_target = 32'h400 + i;
      cyc(); br_valid = 0;
      cyc(); cyc();
    end
    chk("sat4", {bc4, tc4}, 8'hFF);
    chk("wide17", {bc, tc}, {16'd17, 16'd17});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
